// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: accepts one instruction per handshake, runs it through
// a one-cycle execute phase and, for ATC, a bounded memory wait, and counts retirements.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | ready for an instruction; no strobes
// S_EXEC     | one-cycle decode/execute of grp_q/cmd_q; strobes valid here
// S_ATC_WAIT | ATC memory request outstanding until mem_ack or timeout
module multicycle_controller #(
    parameter int ALU_OP_W    = 4,
    parameter int ATC_TIMEOUT = 15,
    parameter int TMO_W       = 4,
    parameter int COUNT_W     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [2:0]          command_group,
    input  logic [2:0]          command,
    input  logic                alu_cond,
    input  logic                mem_ack,
    input  logic                mem_flag,
    output logic                write_enable,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                branch_taken,
    output logic                atc_req,
    output logic                illegal,
    output logic                atc_timeout,
    output logic [COUNT_W-1:0]  retired_count
);

    localparam logic [2:0] GRP_NOP = 3'd0;
    localparam logic [2:0] GRP_MOV = 3'd1;
    localparam logic [2:0] GRP_JMP = 3'd2;
    localparam logic [2:0] GRP_ACC = 3'd3;
    localparam logic [2:0] GRP_ATC = 3'd4;

    localparam logic [2:0] MOV_SHL = 3'd1;
    localparam logic [2:0] MOV_SHR = 3'd2;

    localparam logic [2:0] ACC_UAD = 3'd0;
    localparam logic [2:0] ACC_SAD = 3'd1;
    localparam logic [2:0] ACC_UMT = 3'd2;
    localparam logic [2:0] ACC_SMT = 3'd3;
    localparam logic [2:0] ACC_AND = 3'd4;
    localparam logic [2:0] ACC_OR  = 3'd5;
    localparam logic [2:0] ACC_XOR = 3'd6;

    localparam logic [2:0] JMP_UNC = 3'd0;
    localparam logic [2:0] JMP_EQ  = 3'd1;
    localparam logic [2:0] JMP_ULT = 3'd2;
    localparam logic [2:0] JMP_SLT = 3'd3;
    localparam logic [2:0] JMP_ULE = 3'd4;
    localparam logic [2:0] JMP_SLE = 3'd5;

    localparam logic [ALU_OP_W-1:0] ALU_PUR = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SHL = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SHR = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_UAD = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SAD = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_UMT = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SMT = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_UNC = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = ALU_OP_W'(11);
    localparam logic [ALU_OP_W-1:0] ALU_ULT = ALU_OP_W'(12);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(13);
    localparam logic [ALU_OP_W-1:0] ALU_ULE = ALU_OP_W'(14);
    localparam logic [ALU_OP_W-1:0] ALU_SLE = ALU_OP_W'(15);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ATC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_ATC_WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         grp_q;
    logic [2:0]         cmd_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [COUNT_W-1:0] retired_q;

    assign retired_count = retired_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            grp_q     <= GRP_NOP;
            cmd_q     <= 3'd0;
            tmo_cnt   <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        grp_q <= command_group;
                        cmd_q <= command;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (grp_q == GRP_ATC) begin
                        tmo_cnt <= '0;
                        state   <= S_ATC_WAIT;
                    end else begin
                        retired_q <= retired_q + COUNT_W'(1);
                        state     <= S_IDLE;
                    end
                end
                S_ATC_WAIT: begin
                    // ack and the timeout limit in the same cycle: the ack completes normally
                    if (mem_ack || tmo_cnt == TMO_LAST) begin
                        retired_q <= retired_q + COUNT_W'(1);
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        instr_ready  = 1'b0;
        write_enable = 1'b0;
        alu_op       = ALU_PUR;
        branch_taken = 1'b0;
        atc_req      = 1'b0;
        illegal      = 1'b0;
        atc_timeout  = 1'b0;
        case (state)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                case (grp_q)
                    GRP_NOP: ;
                    GRP_MOV: begin
                        write_enable = 1'b1;
                        case (cmd_q)
                            MOV_SHL: alu_op = ALU_SHL;
                            MOV_SHR: alu_op = ALU_SHR;
                            default: alu_op = ALU_PUR;
                        endcase
                    end
                    GRP_ACC: begin
                        write_enable = 1'b1;
                        case (cmd_q)
                            ACC_UAD: alu_op = ALU_UAD;
                            ACC_SAD: alu_op = ALU_SAD;
                            ACC_UMT: alu_op = ALU_UMT;
                            ACC_SMT: alu_op = ALU_SMT;
                            ACC_AND: alu_op = ALU_AND;
                            ACC_OR:  alu_op = ALU_OR;
                            ACC_XOR: alu_op = ALU_XOR;
                            default: alu_op = ALU_PUR;
                        endcase
                    end
                    GRP_JMP: begin
                        branch_taken = alu_cond;
                        case (cmd_q)
                            JMP_UNC: alu_op = ALU_UNC;
                            JMP_EQ:  alu_op = ALU_EQ;
                            JMP_ULT: alu_op = ALU_ULT;
                            JMP_SLT: alu_op = ALU_SLT;
                            JMP_ULE: alu_op = ALU_ULE;
                            JMP_SLE: alu_op = ALU_SLE;
                            default: begin
                                illegal      = 1'b1;
                                branch_taken = 1'b0;
                            end
                        endcase
                    end
                    GRP_ATC: ;
                    default: illegal = 1'b1;
                endcase
            end
            S_ATC_WAIT: begin
                atc_req = 1'b1;
                if (mem_ack) begin
                    branch_taken = mem_flag;
                end else if (tmo_cnt == TMO_LAST) begin
                    atc_timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized
// instruction streams compared against an arithmetic model of the instruction set.
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam int TMO   = 15;
    localparam int CNT_W = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] command_group = 3'd0;
    logic [2:0] command = 3'd0;
    logic       alu_cond = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_flag = 1'b0;
    logic       write_enable;
    logic [3:0] alu_op;
    logic       branch_taken;
    logic       atc_req;
    logic       illegal;
    logic       atc_timeout;
    logic [CNT_W-1:0] retired_count;

    int checks = 0;
    int failures = 0;
    int model_count = 0;

    multicycle_controller #(
        .ALU_OP_W(4), .ATC_TIMEOUT(TMO), .TMO_W(4), .COUNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .command_group(command_group), .command(command), .alu_cond(alu_cond),
        .mem_ack(mem_ack), .mem_flag(mem_flag), .write_enable(write_enable), .alu_op(alu_op),
        .branch_taken(branch_taken), .atc_req(atc_req), .illegal(illegal),
        .atc_timeout(atc_timeout), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    // Issues one instruction from IDLE (called at a negedge) and checks every phase.
    // ack_at: wait cycle (1..TMO) on which mem_ack is raised; 0 means never.
    task automatic run_instr(input int g, input int c, input logic cond,
                             input int ack_at, input logic flag);
        int exp_we, exp_ill, exp_op, exp_br, waits;
        exp_we  = (g == 1 || g == 3) ? 1 : 0;
        exp_ill = (g >= 5 || (g == 2 && c >= 6)) ? 1 : 0;
        if (g == 1)                exp_op = (c == 1 || c == 2) ? c : 0;
        else if (g == 3)           exp_op = (c <= 6) ? 3 + c : 0;
        else if (g == 2 && c < 6)  exp_op = 10 + c;
        else                       exp_op = 0;
        exp_br = (g == 2 && c < 6) ? int'(cond) : 0;
        waits  = (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO;

        checks++;
        if (instr_ready !== 1'b1 || alu_op !== 4'd0 || atc_req !== 1'b0 ||
            write_enable !== 1'b0 || branch_taken !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs: ready=%b op=%0d req=%b we=%b br=%b ill=%b want 1,0,0,0,0,0",
                     instr_ready, alu_op, atc_req, write_enable, branch_taken, illegal);
        end
        checks++;
        if (retired_count !== CNT_W'(model_count)) begin
            failures++;
            $display("FAIL retired_count: got %0d want %0d", retired_count, model_count);
        end

        instr_valid   = 1'b1;
        command_group = 3'(g);
        command       = 3'(c);
        alu_cond      = cond;
        @(posedge clock); #1;
        instr_valid   = $urandom_range(0, 1);
        command_group = 3'($urandom_range(0, 7));
        command       = 3'($urandom_range(0, 7));
        mem_ack       = $urandom_range(0, 1);
        mem_flag      = $urandom_range(0, 1);
        @(negedge clock);
        checks++;
        if (write_enable !== 1'(exp_we) || alu_op !== 4'(exp_op) || branch_taken !== 1'(exp_br) ||
            illegal !== 1'(exp_ill) || instr_ready !== 1'b0 || atc_req !== 1'b0 || atc_timeout !== 1'b0) begin
            failures++;
            $display("FAIL exec g=%0d c=%0d: we=%b op=%0d br=%b ill=%b rdy=%b req=%b tmo=%b want we=%0d op=%0d br=%0d ill=%0d rdy=0 req=0 tmo=0",
                     g, c, write_enable, alu_op, branch_taken, illegal, instr_ready, atc_req, atc_timeout,
                     exp_we, exp_op, exp_br, exp_ill);
        end

        if (g == 4) begin
            @(posedge clock); #1;
            for (int i = 1; i <= waits; i++) begin
                mem_ack  = (i == ack_at);
                mem_flag = (i == ack_at) ? flag : 1'($urandom_range(0, 1));
                alu_cond = $urandom_range(0, 1);
                @(negedge clock);
                checks++;
                if (atc_req !== 1'b1 || branch_taken !== ((i == ack_at) ? flag : 1'b0) ||
                    atc_timeout !== (ack_at == 0 && i == TMO) || write_enable !== 1'b0 ||
                    instr_ready !== 1'b0 || alu_op !== 4'd0) begin
                    failures++;
                    $display("FAIL atc_wait cycle %0d ack_at=%0d: req=%b br=%b tmo=%b we=%b rdy=%b op=%0d want req=1 br=%b tmo=%b",
                             i, ack_at, atc_req, branch_taken, atc_timeout, write_enable, instr_ready, alu_op,
                             (i == ack_at) ? flag : 1'b0, (ack_at == 0 && i == TMO));
                end
                if (i < waits) begin
                    @(posedge clock); #1;
                end
            end
        end

        @(posedge clock); #1;
        mem_ack     = $urandom_range(0, 1);
        instr_valid = 1'b0;
        model_count = (model_count + 1) % (1 << CNT_W);
        @(negedge clock);
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (instr_ready !== 1'b1 || alu_op !== 4'd0 || write_enable !== 1'b0 || branch_taken !== 1'b0 ||
            atc_req !== 1'b0 || illegal !== 1'b0 || atc_timeout !== 1'b0 || retired_count !== '0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b op=%0d we=%b br=%b req=%b ill=%b tmo=%b cnt=%0d want 1,0,0,0,0,0,0,0",
                     instr_ready, alu_op, write_enable, branch_taken, atc_req, illegal, atc_timeout, retired_count);
        end
        @(negedge clock);
        reset = 1'b0;
        model_count = 0;
        @(negedge clock);
    endtask

    task automatic test_mov_shl();
        run_instr(1, 1, 1'b0, 0, 1'b0);
        run_instr(1, 2, 1'b1, 0, 1'b0);
        run_instr(1, 5, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_instr(3, 6, 1'b0, 0, 1'b0);
        run_instr(2, 1, 1'b1, 0, 1'b0);
        run_instr(2, 2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_atc();
        run_instr(4, 0, 1'b0, 3, 1'b1);
        run_instr(4, 3, 1'b1, 1, 1'b0);
        run_instr(4, 0, 1'b0, 0, 1'b0);
        run_instr(4, 0, 1'b0, TMO, 1'b1);
    endtask

    task automatic test_illegal();
        run_instr(7, 0, 1'b1, 0, 1'b0);
        run_instr(2, 7, 1'b1, 0, 1'b0);
        run_instr(5, 3, 1'b1, 0, 1'b0);
        run_instr(2, 6, 1'b1, 0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) run_instr(0, i % 8, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                      $urandom_range(0, TMO), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_atc();
        instr_valid   = 1'b1;
        command_group = 3'd4;
        command       = 3'd0;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #2;
        checks++;
        if (atc_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_atc_req: got %b want 1", atc_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (atc_req !== 1'b0 || instr_ready !== 1'b1 || alu_op !== 4'd0 || retired_count !== '0) begin
            failures++;
            $display("FAIL reset_mid_atc: req=%b rdy=%b op=%0d cnt=%0d want 0,1,0,0",
                     atc_req, instr_ready, alu_op, retired_count);
        end
        @(negedge clock);
        reset = 1'b0;
        model_count = 0;
        @(negedge clock);
        run_instr(3, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mov_shl();
        test_back_to_back();
        test_atc();
        test_illegal();
        test_wrap();
        test_random();
        test_reset_mid_atc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequential, parametrised successor to the CPU's combinational control unit. Accepts one instruction per valid/ready handshake and holds it in a register. It then steps a small FSM through execute and, for ATC, a bounded memory handshake, producing single-cycle write and branch strobes. It sits between instruction fetch and the ALU, register file and instruction pointer, and adds illegal-instruction detection, an ATC timeout and a retired-instruction counter.

## Interface
- ALU_OP_W, 4, width of alu_op; must hold every ALU_* code from cpu_definitions.vh
- ATC_TIMEOUT, 15, maximum ATC_WAIT cycles before abort; legal range 1..2^TMO_W-1
- TMO_W, 4, width of the timeout counter
- COUNT_W, 16, width of retired_count
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  fetch presents an instruction
- instr_ready  out  1  controller can accept an instruction
- command_group  in  3  instruction group (NOP, MOV, JMP, ACC, ATC per cpu_definitions.vh)
- command  in  3  sub-command within the group
- alu_cond  in  1  ALU condition result, sampled in EXEC for JMP
- mem_ack  in  1  memory completes the ATC read-and-clear
- mem_flag  in  1  value tested by ATC, valid with mem_ack
- write_enable  out  1  register-file write strobe
- alu_op  out  ALU_OP_W  ALU operation select
- branch_taken  out  1  load instruction pointer from branch target
- atc_req  out  1  ATC memory request, held until ack or timeout
- illegal  out  1  pulse: undefined group or JMP sub-command
- atc_timeout  out  1  pulse: ATC aborted
- retired_count  out  COUNT_W  instructions completed, including faults

## Operation
States: IDLE, EXEC, ATC_WAIT.

- **IDLE:** instr_ready=1. On instr_valid & instr_ready, latch command_group/command into grp_q/cmd_q and go to EXEC. Otherwise stay.
- **EXEC (exactly one cycle):** decode from grp_q/cmd_q.
  - NOP: no strobes; alu_op=ALU_PUR; go to IDLE.
  - MOV: write_enable=1; alu_op = PUR→ALU_PUR, SHL→ALU_SHL, SHR→ALU_SHR, other→ALU_PUR; go to IDLE.
  - ACC: write_enable=1; alu_op = UAD/SAD/UMT/SMT/AND/OR/XOR → matching ALU_* code, other→ALU_PUR; go to IDLE.
  - JMP: alu_op = UNC/EQ/ULT/SLT/ULE/SLE → matching ALU_* code; branch_taken=alu_cond. An undefined sub-command gives illegal=1, branch_taken=0 and alu_op=ALU_PUR. Go to IDLE.
  - ATC: alu_op=ALU_PUR; load timeout counter with 0; go to ATC_WAIT.
  - Group codes outside the five defined: illegal=1, no strobes, go to IDLE.
- **ATC_WAIT:** atc_req=1.
  - If mem_ack: branch_taken=mem_flag for this cycle, go to IDLE.
  - Else if counter==ATC_TIMEOUT-1: atc_timeout=1, branch_taken=0, go to IDLE.
  - Else counter+1.
- **retired_count:** +1 on every transition into IDLE from EXEC or ATC_WAIT. Wraps modulo 2^COUNT_W.
- **Reset:** outputs are combinational from the registered state and grp_q/cmd_q. While reset is high: state=IDLE, grp_q=NOP, counters 0. All outputs read 0 except alu_op=ALU_PUR and instr_ready=1. Inputs have no effect until the first rising edge after reset deasserts.

## Timing
- Accept at edge N; EXEC strobes are valid between edges N and N+1; instr_ready returns at N+1.
- Latency: 2 cycles per non-ATC instruction. ATC takes 2+k cycles, where k is the wait cycles until ack (max ATC_TIMEOUT).
- write_enable, branch_taken, illegal and atc_timeout are each high for at most one cycle per instruction.
- branch_taken in EXEC is combinational on alu_cond. In ATC_WAIT it is combinational on mem_ack & mem_flag.
- mem_ack in the same cycle as the timeout limit: ack wins and no timeout is flagged.
- mem_ack outside ATC_WAIT is ignored. instr_valid outside IDLE is ignored; fetch must hold the instruction until ready.
- Reset mid-ATC drops atc_req asynchronously, and the instruction is not retired.

## Test plan
- Reset asserted mid-ATC_WAIT → atc_req=0 immediately; after release, instr_ready=1, alu_op=ALU_PUR, retired_count=0.
- MOV/SHL at edge 0 → edge 0–1: write_enable=1, alu_op=ALU_SHL; edge 1: instr_ready=1, retired_count=1.
- Back-to-back ACC/XOR, JMP/EQ (alu_cond=1), JMP/ULT (alu_cond=0) → write_enable once, then branch_taken=1 once, then none; retired_count=3 after 6 cycles.
- ATC, mem_ack with mem_flag=1 on 3rd wait cycle → atc_req high 3 cycles, branch_taken pulse, atc_timeout=0.
- ATC, ATC_TIMEOUT=15, mem_ack never asserted → atc_req high 15 cycles, atc_timeout pulse, branch_taken=0, retired_count+1.
- Group code 7, then JMP with sub-command 7 → two illegal pulses, no write/branch strobes. With COUNT_W=4, 16 retirements wrap retired_count to 0.
